// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - WIDTH-bit add/sub computed one nibble per clock through a single 4-bit slice
// Operands are captured on acceptance, walked LSB nibble first, and the result is held until consumed.

module nibble_add4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] s_o,
    output logic       cout_o
);
    logic [4:0] full;

    assign full   = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};
    assign s_o    = full[3:0];
    assign cout_o = full[4];
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16,
    localparam int NIB  = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  beff_q, beff_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [IDXW+1:0]   base;
    logic [3:0]        slice_a;
    logic [3:0]        slice_b;
    logic [3:0]        slice_s;
    logic              slice_c;

    assign base    = {idx_q, 2'b00};
    assign slice_a = a_q[base +: 4];
    assign slice_b = beff_q[base +: 4];

    nibble_add4 u_slice (
        .a_i    (slice_a),
        .b_i    (slice_b),
        .cin_i  (carry_q),
        .s_o    (slice_s),
        .cout_o (slice_c)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        beff_d  = beff_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    // Subtraction is A + ~B + 1, so the invert and the forced carry replace cin.
                    beff_d  = sub ? ~b : b;
                    carry_d = sub | cin;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d[base +: 4] = slice_s;
                carry_d          = slice_c;
                idx_d            = idx_q + IDXW'(1);
                if (idx_q == LAST_IDX) begin
                    // slice_s[3] is the MSB being written this edge.
                    cout_d  = slice_c;
                    ovf_d   = (a_q[WIDTH-1] == beff_q[WIDTH-1]) && (slice_s[3] != a_q[WIDTH-1]);
                    idx_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            beff_q  <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            beff_q  <= beff_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - randomized and directed bench for nibble_serial_adder against an arithmetic model
// The model tracks the handshake by edge counting and results by signed/unsigned integer arithmetic.

module tb_nibble_serial_adder;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    int passed = 0;
    int total  = 0;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference model: busy counts edges since acceptance, done means a result awaits consumption.
    bit               m_busy = 0;
    bit               m_done = 0;
    int               m_cnt  = 0;
    logic [WIDTH-1:0] m_sum  = '0;
    logic             m_cout = 1'b0;
    logic             m_ovf  = 1'b0;
    logic [WIDTH-1:0] p_sum;
    logic             p_cout;
    logic             p_ovf;

    always @(posedge clk) begin
        int ua, ub, r;
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_cnt = 0;
            m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
        end else if (!m_busy && !m_done && in_valid) begin
            m_busy = 1;
            m_cnt  = 0;
            ua = int'(a);
            ub = int'(b);
            if (sub) begin
                p_sum  = WIDTH'(ua - ub);
                p_cout = (ua >= ub);
                r      = int'($signed(a)) - int'($signed(b));
            end else begin
                p_sum  = WIDTH'(ua + ub + int'(cin));
                p_cout = (ua + ub + int'(cin)) >= (1 << WIDTH);
                r      = int'($signed(a)) + int'($signed(b)) + int'(cin);
            end
            p_ovf = (r > (1 << (WIDTH - 1)) - 1) || (r < -(1 << (WIDTH - 1)));
        end else if (m_busy) begin
            m_cnt++;
            if (m_cnt == NIB) begin
                m_busy = 0;
                m_done = 1;
                m_sum  = p_sum;
                m_cout = p_cout;
                m_ovf  = p_ovf;
            end
        end else if (m_done && out_ready) begin
            m_done = 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n !== 1'bx) begin
            chk("in_ready", in_ready, !m_busy && !m_done);
            chk("out_valid", out_valid, m_done);
            if (!m_busy) begin
                chk("sum", sum, m_sum);
                chk("cout", cout, m_cout);
                chk("overflow", overflow, m_ovf);
            end
        end
    end

    task automatic op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv,
                      input logic sv, input bit lit, input logic [WIDTH-1:0] es, input logic ec,
                      input logic ev, input int hold);
        int k;
        bit ok;
        logic [WIDTH-1:0] s0;
        logic c0, v0;
        a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1; out_ready = 1'b0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        chk("accept_timeout", ok, 1'b1);
        @(posedge clk); #1;
        k = 0;
        ok = 0;
        for (int i = 1; i <= 20; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            a = WIDTH'($urandom); b = WIDTH'($urandom);
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (out_valid) begin k = i; ok = 1; break; end
        end
        chk("result_timeout", ok, 1'b1);
        chk("latency", k, NIB);
        if (lit) begin
            chk("lit_sum", sum, es);
            chk("lit_cout", cout, ec);
            chk("lit_ovf", overflow, ev);
            chk("model_sum", p_sum, es);
            chk("model_flags", {p_cout, p_ovf}, {ec, ev});
        end
        s0 = sum; c0 = cout; v0 = overflow;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_result", {sum, cout, overflow}, {s0, c0, v0});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("consumed_ready", in_ready, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", {sum, cout, overflow}, 18'h0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_nothing_accepted", in_ready, 1'b1);

        op(16'h0001, 16'h0001, 1'b1, 1'b0, 1, 16'h0003, 1'b0, 1'b0, 0);
        op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1, 16'h0000, 1'b1, 1'b0, 0);
        op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1, 16'h8000, 1'b0, 1'b1, 0);
        op(16'h0005, 16'h0007, 1'b1, 1'b1, 1, 16'hFFFE, 1'b0, 1'b0, 3);
        op(16'h8000, 16'h0001, 1'b0, 1'b1, 1, 16'h7FFF, 1'b1, 1'b1, 3);

        // Reset after nibble 1 lands (edge E2), held for one edge.
        a = 16'hAAAA; b = 16'h5555; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_ready", in_ready, 1'b1);
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_sum", sum, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_valid", out_valid, 1'b0);
        end
        op(16'h1234, 16'h1111, 1'b0, 1'b0, 1, 16'h2345, 1'b0, 1'b0, 0);

        for (int n = 0; n < 60; n++) begin
            op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 0, '0, 1'b0, 1'b0, $urandom_range(0, 2));
        end

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle WIDTH-bit adder/subtractor that sends operands through one 4-bit adder slice, one nibble per clock, least-significant nibble first. A carry register links the nibbles. It sits directly upstream of the 4-bit add stage and drives its a/b/cin inputs. It widens that stage to full ALU operand width without replicating the slice. Operands enter and results leave through valid/ready handshakes.

## Interface
- WIDTH, 16, operand width in bits. Must be a multiple of 4 and at least 8.
- NIB, WIDTH/4, derived nibble count. Not overridable.
- clk  in  1  rising-edge clock for all state.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept operands. High only in IDLE.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in. Used only when sub=0.
- sub  in  1  1 selects A − B. 0 selects A + B + cin.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the MSB. When sub=1, cout=1 means no borrow.
- overflow  out  1  two's-complement overflow.

## Operation
- The states are IDLE, RUN and DONE.
- **IDLE**
  - in_ready=1.
  - On an edge with in_valid=1, the block captures a, b and sub into internal registers.
  - Effective B = sub ? ~b : b.
  - Carry register = sub ? 1 : cin.
  - Nibble index = 0, then go to RUN.
- **RUN**
  - Each cycle the block drives slice a = A[4i+3:4i], b = Beff[4i+3:4i], cin = carry register, where i is the nibble index.
  - At the edge, the slice out is written to sum[4i+3:4i], the slice cout goes to the carry register, and the index increments.
  - After nibble NIB−1 is written:
    - cout = final slice carry.
    - overflow = (A[WIDTH−1] == Beff[WIDTH−1]) && (sum[WIDTH−1] != A[WIDTH−1]).
    - State goes to DONE.
- **DONE**
  - out_valid=1.
  - sum, cout and overflow stay stable until out_ready=1 is seen at an edge, then state goes to IDLE.
- Arithmetic is modulo 2^WIDTH. The result must equal (A + Beff + carry-in) for every input.
- Inputs are sampled only at acceptance. Changes to a, b, cin or sub afterwards have no effect.
- in_valid is ignored outside IDLE.
- In IDLE, sum, cout and overflow hold their last values and out_valid=0.
- Reset is asserted at an edge (in any state, including mid-RUN):
  - State goes to IDLE and the nibble index to 0.
  - sum, cout, overflow, the carry register and out_valid all go to 0.
  - The in-flight operation is discarded and no out_valid pulse follows.

## Timing
- Reset values: in_ready=1, out_valid=0, sum=0, cout=0, overflow=0.
- Acceptance happens at edge E0 (in_valid && in_ready).
- Nibble i is registered at edge E(i+1).
- out_valid is high after edge E(NIB). With WIDTH=16, latency is 4 edges from acceptance.
- With out_ready held high, the result is consumed at E(NIB+1) and in_ready is high again after that edge. The minimum initiation interval is NIB+2 cycles.
- in_ready and out_valid are never high in the same cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- **Reset:** hold rst_n=0 for 2 edges with in_valid=1 → in_ready=1, out_valid=0, sum=0x0000, cout=0, overflow=0, and nothing is accepted.
- **Basic add:** a=0x0001, b=0x0001, cin=1, sub=0 → sum=0x0003, cout=0, overflow=0. out_valid rises exactly 4 edges after acceptance.
- **Full carry ripple:** a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, overflow=0. Also a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, overflow=1.
- **Subtract:**
  - a=0x0005, b=0x0007, sub=1, cin=1 → sum=0xFFFE, cout=0, overflow=0.
  - a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, overflow=1.
- **Backpressure and ignored input:**
  - Hold out_ready=0 for 3 cycles in DONE → out_valid stays 1 and sum/cout/overflow are unchanged.
  - Toggle in_valid and operands during RUN → result is unaffected.
- **Reset mid-operation:** drop rst_n for one edge after nibble 1 is written → next cycle is IDLE with sum=0 and out_valid=0, with no later out_valid. A fresh 0x1234+0x1111 then yields 0x2345.
